// File: rtl/hazard_unit_mc_pkg.sv
// Shared types for the hazard unit and its multi-cycle scoreboard.
package hazard_unit_mc_pkg;

  localparam int REG_W_DEF = 5;

  // E-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // multi-cycle unit occupancy
  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-side view of the hazard unit: stage register indices in,
// forwarding selects, stall/flush and mc status out.
interface hazard_unit_mc_if
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int STALLCNT_W = 16
);
  logic [REG_W-1:0]      rsD, rtD, rsE, rtE;
  logic [REG_W-1:0]      writeregE, writeregM, writeregW;
  logic                  regwriteE, regwriteM, regwriteW;
  logic                  memtoregE, memtoregM;
  logic                  branchD;
  logic                  mcstartE;
  logic [REG_W-1:0]      mcdestE;

  logic                  forwardaD, forwardbD;
  fwd_sel_e              forwardaE, forwardbE;
  logic                  stallF, stallD, flushE;
  logic                  mcbusy, mcdone;
  logic [REG_W-1:0]      mcdest_q;
  logic [STALLCNT_W-1:0] stallcnt;

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, mcstartE, mcdestE,
    output forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, flushE, mcbusy, mcdone, mcdest_q, stallcnt
  );

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, mcstartE, mcdestE,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, flushE, mcbusy, mcdone, mcdest_q, stallcnt
  );
endinterface

// File: rtl/hazard_unit_mc_scoreboard.sv
// Tracks the single in-flight multi-cycle op: pending-register bits,
// latency countdown, done pulse and destination.
module mc_scoreboard
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int MC_LAT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [REG_W-1:0]      dest_i,
  output logic [2**REG_W-1:0]   pend_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [REG_W-1:0]      dest_o
);
  localparam int NREGS = 2**REG_W;
  localparam int CNT_W = $clog2(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT-1);

  mc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREGS-1:0]   pend_q, pend_d;
  logic [REG_W-1:0]   dest_q, dest_d;
  logic               done, accept;

  assign done   = (state_q == MC_BUSY) && (cnt_q == '0);
  // back-to-back issue is only legal on the completing cycle
  assign accept = start_i && ((state_q == MC_IDLE) || done);

  // next state: countdown, retire on done, reload on accepted issue
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dest_d  = dest_q;
    case (state_q)
      MC_IDLE: if (start_i) state_d = MC_BUSY;
      MC_BUSY: begin
        if (done) state_d = start_i ? MC_BUSY : MC_IDLE;
        else      cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = MC_IDLE;
    endcase
    // clear before set so a same-register reissue stays pending
    if (done) pend_d[dest_q] = 1'b0;
    if (accept) begin
      cnt_d  = CNT_LOAD;
      dest_d = dest_i;
      if (dest_i != '0) pend_d[dest_i] = 1'b1;
    end
  end

  // state registers; reset abandons any in-flight result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dest_q  <= dest_d;
    end
  end

  // the decoder must hold a new mc op while the unit is occupied
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(start_i && (state_q == MC_BUSY) && !done));
  end

  assign pend_o = pend_q;
  assign busy_o = (state_q == MC_BUSY);
  assign done_o = done;
  assign dest_o = dest_q;
endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller: forwarding selects, load-use / branch / scoreboard /
// WAW stalls, and a saturating stall-cycle counter.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int MC_LAT     = 4,
  parameter int STALLCNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_mc_if.slave  hz
);
  localparam logic [REG_W-1:0] R0 = '0;

  logic [2**REG_W-1:0]   pend;
  logic                  mcbusy, mcdone;
  logic [REG_W-1:0]      mcdest;
  logic                  lwstall, brstall, scstall, wawstall, stall;
  fwd_sel_e              fwda_e, fwdb_e;
  logic [STALLCNT_W-1:0] stallcnt_q, stallcnt_d;

  mc_scoreboard #(.REG_W(REG_W), .MC_LAT(MC_LAT)) u_sb (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (hz.mcstartE),
    .dest_i  (hz.mcdestE),
    .pend_o  (pend),
    .busy_o  (mcbusy),
    .done_o  (mcdone),
    .dest_o  (mcdest)
  );

  // E-stage forwarding, M wins over W; r0 is never forwarded
  always_comb begin
    fwda_e = FWD_RF;
    fwdb_e = FWD_RF;
    if (hz.rsE != R0 && hz.regwriteW && hz.rsE == hz.writeregW) fwda_e = FWD_W;
    if (hz.rsE != R0 && hz.regwriteM && hz.rsE == hz.writeregM) fwda_e = FWD_M;
    if (hz.rtE != R0 && hz.regwriteW && hz.rtE == hz.writeregW) fwdb_e = FWD_W;
    if (hz.rtE != R0 && hz.regwriteM && hz.rtE == hz.writeregM) fwdb_e = FWD_M;
  end

  // stall sources; a pending reg completing this cycle reads write-first
  always_comb begin
    lwstall  = hz.memtoregE && hz.rtE != R0 &&
               (hz.rsD == hz.rtE || hz.rtD == hz.rtE);
    brstall  = hz.branchD &&
               ((hz.regwriteE && hz.writeregE != R0 &&
                 (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
                (hz.memtoregM && hz.writeregM != R0 &&
                 (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));
    scstall  = (hz.rsD != R0 && pend[hz.rsD] && !(mcdone && mcdest == hz.rsD)) ||
               (hz.rtD != R0 && pend[hz.rtD] && !(mcdone && mcdest == hz.rtD));
    wawstall = hz.regwriteE && hz.writeregE != R0 && pend[hz.writeregE];
    stall    = lwstall || brstall || scstall || wawstall;
  end

  // stall counter saturates at all-ones
  always_comb begin
    stallcnt_d = stallcnt_q;
    if (stall && stallcnt_q != '1) stallcnt_d = stallcnt_q + STALLCNT_W'(1);
  end

  // stall counter register
  always_ff @(posedge clk) begin
    if (reset) stallcnt_q <= '0;
    else       stallcnt_q <= stallcnt_d;
  end

  assign hz.forwardaD = hz.rsD != R0 && hz.regwriteM && hz.rsD == hz.writeregM;
  assign hz.forwardbD = hz.rtD != R0 && hz.regwriteM && hz.rtD == hz.writeregM;
  assign hz.forwardaE = fwda_e;
  assign hz.forwardbE = fwdb_e;
  assign hz.stallD    = stall;
  assign hz.stallF    = stall;
  assign hz.flushE    = stall;
  assign hz.mcbusy    = mcbusy;
  assign hz.mcdone    = mcdone;
  assign hz.mcdest_q  = mcdest;
  assign hz.stallcnt  = stallcnt_q;
endmodule
